// File: rtl/g_lut_sched.sv
// rtl/g_lut_sched.sv - shared g-LUT lookup scheduler for one multi-exposure pixel tuple
// Issues NUM_EXP back-to-back lookups, then collects the g values into one result tuple.
module g_lut_sched #(
   parameter int NUM_EXP = 3,
   parameter int PIX_W   = 5,
   parameter int G_W     = 8,
   parameter int LUT_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_EXP*PIX_W-1:0] in_pix,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_EXP*G_W-1:0]   out_g,
   output logic                     lut_clk_en,
   output logic [PIX_W-1:0]         lut_pixel,
   input  logic [G_W-1:0]           lut_data,
   output logic                     busy
);
   localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EXP - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

   state_t                 state_q;
   logic [IDX_W-1:0]       idx_q;
   logic [IDX_W-1:0]       idx_d;
   logic [PIX_W-1:0]       code_q [NUM_EXP];
   logic                   pv_q   [LUT_LAT];
   logic                   pv_d   [LUT_LAT];
   logic [IDX_W-1:0]       pidx_q [LUT_LAT];
   logic [IDX_W-1:0]       pidx_d [LUT_LAT];
   logic                   pipe_empty_d;
   logic [NUM_EXP*G_W-1:0] out_g_q;
   logic                   out_valid_q;
   logic                   lut_clk_en_q;
   logic [PIX_W-1:0]       lut_pixel_q;

   // Capture pipeline mirrors the LUT latency: each issue tags which slot its data lands in.
   always_comb begin
      idx_d     = idx_q + 1'b1;
      pv_d[0]   = (state_q == ISSUE);
      pidx_d[0] = idx_q;
      for (int i = 1; i < LUT_LAT; i++) begin
         pv_d[i]   = pv_q[i-1];
         pidx_d[i] = pidx_q[i-1];
      end
      pipe_empty_d = 1'b1;
      for (int i = 0; i < LUT_LAT; i++) begin
         if (pv_d[i]) pipe_empty_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         out_g_q      <= '0;
         out_valid_q  <= 1'b0;
         lut_clk_en_q <= 1'b0;
         lut_pixel_q  <= '0;
         for (int e = 0; e < NUM_EXP; e++) code_q[e] <= '0;
         for (int i = 0; i < LUT_LAT; i++) begin
            pv_q[i]   <= 1'b0;
            pidx_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LUT_LAT; i++) begin
            pv_q[i]   <= pv_d[i];
            pidx_q[i] <= pidx_d[i];
         end
         // lut_data is only trusted when a tagged lookup reaches the tail.
         if (pv_q[LUT_LAT-1]) begin
            for (int e = 0; e < NUM_EXP; e++) begin
               if (pidx_q[LUT_LAT-1] == IDX_W'(e)) out_g_q[e*G_W +: G_W] <= lut_data;
            end
         end
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  for (int e = 0; e < NUM_EXP; e++) code_q[e] <= in_pix[e*PIX_W +: PIX_W];
                  idx_q        <= '0;
                  lut_pixel_q  <= in_pix[PIX_W-1:0];
                  lut_clk_en_q <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               if (idx_q == LAST_IDX) begin
                  lut_clk_en_q <= 1'b0;
                  state_q      <= DRAIN;
               end else begin
                  idx_q       <= idx_d;
                  lut_pixel_q <= code_q[idx_d];
               end
            end
            DRAIN: begin
               if (pipe_empty_d) begin
                  out_valid_q <= 1'b1;
                  state_q     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign out_valid  = out_valid_q;
   assign out_g      = out_g_q;
   assign lut_clk_en = lut_clk_en_q;
   assign lut_pixel  = lut_pixel_q;

endmodule

// File: doc/g_lut_sched.md
Name: g_lut_sched

Overview:
Scheduler that time-multiplexes one shared camera-response (g) lookup table across the NUM_EXP exposures of a single pixel location. It accepts one pixel tuple (one PIX_W code per exposure) and issues the LUT lookups back-to-back on consecutive cycles. It collects the returned G_W-bit g values and presents them as one result tuple. It sits between the exposure-alignment stage and the HDR weighting/merge stage, one instance per colour channel, with the channel's g LUT instance attached.

Parameters:
NUM_EXP, 3, exposures per pixel tuple (≥2)
PIX_W, 5, pixel code width (LUT address width)
G_W, 8, g value width (LUT data width)
LUT_LAT, 1, cycles from LUT address/enable sample to valid lut_data (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input tuple valid
in_ready  out  1  scheduler can accept a tuple
in_pix  in  NUM_EXP*PIX_W  exposure codes, exposure e at bits [e*PIX_W +: PIX_W]
out_valid  out  1  result tuple valid
out_ready  in  1  downstream accepts result
out_g  out  NUM_EXP*G_W  g values, exposure e at bits [e*G_W +: G_W]
lut_clk_en  out  1  enable to shared LUT; LUT holds output when low
lut_pixel  out  PIX_W  address to shared LUT
lut_data  in  G_W  registered LUT output
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, issue index=0, capture pipeline cleared, out_g=0, out_valid=0, lut_clk_en=0, lut_pixel=0, busy=0. in_ready is decoded from state, so it reads 1 during reset. Input is ignored while rst_n is low. Reset mid-tuple discards the tuple with no partial output.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: in_ready=1. On in_valid&in_ready: latch in_pix, idx←0, go ISSUE.
- ISSUE: in_ready=0, lut_clk_en=1, lut_pixel=latched code[idx]. idx increments each cycle. When idx=NUM_EXP-1 go DRAIN. Exactly NUM_EXP enabled cycles per tuple, in exposure order 0..NUM_EXP-1.
- Capture: each issue pushes {valid, idx} into a LUT_LAT-deep shift register. When the tail entry is valid, lut_data is written into out_g slot idx at that edge. lut_data is never sampled otherwise, so the uninitialised LUT output after power-up is never captured.
- DRAIN: lut_clk_en=0, lut_pixel holds its last value. Stay until the capture pipeline is empty (LUT_LAT cycles), then go OUT.
- OUT: out_valid=1, out_g stable. On out_ready go IDLE. in_ready rises the following cycle; there is no same-cycle bypass. out_g holds its value after handoff until overwritten by the next tuple.
- Latency: accept edge at cycle T → out_valid high in cycle T+NUM_EXP+LUT_LAT+1 (T+5 at defaults). Throughput is one tuple per NUM_EXP+LUT_LAT+2 cycles minimum (6 at defaults).
- Backpressure: out_ready low holds OUT indefinitely with all outputs stable and lut_clk_en=0.
- in_valid may drop or in_pix may change during ISSUE/DRAIN/OUT; neither has any effect (codes were latched).
- in_valid asserted in the same cycle the handoff completes in OUT: not accepted; it is accepted the next cycle in IDLE.
- lut_clk_en is never high outside ISSUE.
- No arithmetic on codes or g values; values pass through unchanged.

Test Plan:
- Reset then single tuple, bench LUT = blue response table, in_pix={0x1F,0x10,0x01} (e2,e1,e0) accepted at T → lut_pixel 0x01,0x10,0x1F at T+1..T+3 with lut_clk_en high exactly those cycles; out_valid at T+5, out_g={0x49,0x32,0x0B}.
- Backpressure: out_ready low 10 cycles in OUT → out_valid and out_g stable, in_ready=0, lut_clk_en=0 throughout; out_ready high → IDLE next cycle, in_ready=1.
- Back-to-back streaming, in_valid always high, out_ready always high, tuples {0x00,0x00,0x00} then {0x1A,0x19,0x1F} → results {0x00,0x00,0x00} then {0x40,0x40,0x49}, accepts 6 cycles apart.
- Input churn: change in_pix to 0x1F,0x1F,0x1F and drop in_valid during ISSUE → result matches the originally latched tuple; no extra lookup issued.
- Async reset asserted during ISSUE idx=1 → all outputs at reset values immediately; after release no out_valid until a new tuple; next tuple {0x0A,0x05,0x02} → {0x26,0x1D,0x11}.
- LUT_LAT=2 build with a 2-stage bench LUT model → out_valid at T+6, values correct; no capture in the cycle directly after the first issue.
